// File: rtl/les_pkg.sv
// Shared types and helpers for the les_arbiter block that shares one les_top core.
// The optional watchdog is enabled by defining LES_ARB_TIMEOUT_EN.
package les_pkg;

  localparam int LES_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RESP
  } les_arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int les_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/les_rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps, so the
// requester named by ptr has the lowest priority.
module les_rr_arbiter
  import les_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = les_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/les_arbiter.sv
// Shares one les_top core between N_REQ requesters: round-robin grant, then
// clr -> start -> busy high -> busy low, result returned to the owner.
// Optional watchdog abort is enabled by defining LES_ARB_TIMEOUT_EN.
//
// Handshakes: a transfer happens on a clock edge where valid & ready are both 1.
// Request side: req_ready is one-hot, driven only in IDLE. Response side:
// resp_valid[grant_id] is held with stable resp_data until resp_ready[grant_id].
module les_arbiter
  import les_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = LES_DATA_W,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int IW = les_idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_err,
  output logic                    les_clr,
  output logic                    les_start,
  output logic [DATA_W-1:0]       les_plaintext,
  input  logic [DATA_W-1:0]       les_cipher,
  input  logic                    les_busy,
  output logic [IW-1:0]           grant_id,
  output les_arb_state_t          dbg_state
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("les_arbiter: parameter out of range");
  end

  les_arb_state_t   state, state_nx;
  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             in_wait;
  logic             timeout;
  logic             done;

  les_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign dbg_state = state;
  assign in_wait   = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
  assign done      = (state == ST_WAIT_LO) && !les_busy && !timeout;

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    les_clr    = 1'b0;
    les_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_any) begin
          req_ready = win_oh;
          state_nx  = ST_CLR;
        end
      end
      ST_CLR: begin
        les_clr  = 1'b1;
        state_nx = ST_START;
      end
      ST_START: begin
        les_start = 1'b1;
        state_nx  = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (timeout)       state_nx = ST_RESP;
        else if (les_busy) state_nx = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (timeout || !les_busy) state_nx = ST_RESP;
      end
      ST_RESP: begin
        resp_valid[grant_id] = 1'b1;
        if (resp_ready[grant_id]) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      ptr           <= IW'(N_REQ - 1);
      grant_id      <= '0;
      les_plaintext <= '0;
      resp_data     <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && win_any) begin
        les_plaintext <= req_data[int'(win_idx)*DATA_W +: DATA_W];
        grant_id      <= win_idx;
        ptr           <= win_idx;
      end
      if (done)    resp_data <= les_cipher;
      if (timeout) resp_data <= '0;
    end
  end

`ifdef LES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // Counts cycles spent in WAIT_HI/WAIT_LO; cleared while issuing start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_START) wd_cnt <= '0;
      else if (in_wait)      wd_cnt <= wd_cnt + 1'b1;
      if (done)              err_q  <= 1'b0;
      else if (timeout)      err_q  <= 1'b1;
    end
  end

  assign timeout  = in_wait && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign resp_err = err_q;
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_les_arbiter.sv
// Self-checking bench for les_arbiter with a behavioural les_top core model.
// Define LES_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
`timescale 1ns/1ps
module tb_les_arbiter;
  import les_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '0;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           les_clr;
  logic           les_start;
  logic [W-1:0]   les_plaintext;
  logic [W-1:0]   les_cipher;
  logic           les_busy = 1'b0;
  logic [1:0]     grant_id;
  les_arb_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout bench did not complete");
    $fatal(1);
  end

  les_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .les_clr(les_clr), .les_start(les_start),
    .les_plaintext(les_plaintext), .les_cipher(les_cipher), .les_busy(les_busy),
    .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // ---------------- core model ----------------
  int busy_len = 32;
  int busy_delay = 0;
  bit stuck = 1'b0;
  int bcnt = 0;
  int dcnt = 0;
  logic [W-1:0] pt_lat = '0;

  function automatic logic [W-1:0] cipher_f(input logic [W-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign les_cipher = cipher_f(pt_lat);

  always @(posedge clk) begin
    if (les_clr) begin
      les_busy <= 1'b0; bcnt <= 0; dcnt <= 0;
    end else if (les_start) begin
      pt_lat <= les_plaintext;
      if (busy_delay == 0) begin les_busy <= 1'b1; bcnt <= busy_len; end
      else dcnt <= busy_delay;
    end else if (dcnt != 0) begin
      if (dcnt == 1) begin les_busy <= 1'b1; bcnt <= busy_len; end
      dcnt <= dcnt - 1;
    end else if (les_busy && !stuck) begin
      if (bcnt == 1) les_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; req_valid = '0; resp_ready = '0;
    exp_q.delete();
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic issue(input int r, input logic [W-1:0] d);
    req_data[r*W +: W] = d;
    req_valid[r] = 1'b1;
    #1;
  endtask

  task automatic wait_resp(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (resp_valid != '0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE);
    checks++; if (req_ready !== 4'b0 || resp_valid !== 4'b0) $display("FAIL reset_hs got ready=%b valid=%b want 0", req_ready, resp_valid);
    checks++; if (resp_data !== '0 || resp_err !== 1'b0) $display("FAIL reset_resp got data=%h err=%b want 0", resp_data, resp_err);
    checks++; if (les_clr !== 1'b0 || les_start !== 1'b0 || les_plaintext !== '0 || grant_id !== 2'd0)
      $display("FAIL reset_core got clr=%b start=%b pt=%h gid=%0d want 0", les_clr, les_start, les_plaintext, grant_id);
    if (dbg_state !== ST_IDLE || req_ready !== 4'b0 || resp_valid !== 4'b0 || resp_data !== '0 || resp_err !== 1'b0 ||
        les_clr !== 1'b0 || les_start !== 1'b0 || les_plaintext !== '0 || grant_id !== 2'd0) errors++;
    apply_reset();
  endtask

  task automatic test_single_op();
    int c0; bit ok; logic [W-1:0] e;
    apply_reset();
    busy_len = 32; busy_delay = 0;
    issue(0, 32'hACE1_ACE1);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
    c0 = cyc;
    exp_q.push_back(cipher_f(32'hACE1_ACE1));
    tick(); req_valid = '0;
    checks++; if (les_clr !== 1'b1 || les_start !== 1'b0) begin errors++; $display("FAIL single_clr got clr=%b start=%b want 1 0", les_clr, les_start); end
    tick();
    checks++; if (les_start !== 1'b1 || les_clr !== 1'b0) begin errors++; $display("FAIL single_start got start=%b clr=%b want 1 0", les_start, les_clr); end
    checks++; if (les_plaintext !== 32'hACE1_ACE1) begin errors++; $display("FAIL single_pt got %h want ace1ace1", les_plaintext); end
    wait_resp(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait got no resp_valid want resp_valid"); end
    checks++; if (cyc - c0 != 36) begin errors++; $display("FAIL single_latency got %0d want 36", cyc - c0); end
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_valid got %b want 0001", resp_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (resp_data !== e) begin errors++; $display("FAIL single_data got %h want %h", resp_data, e); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", resp_err); end
    resp_ready = 4'b0001; tick(); resp_ready = '0;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL single_return got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_round_robin();
    int g; bit ok; bit bad; logic [W-1:0] acc; logic [W-1:0] e;
    apply_reset();
    busy_len = 4; busy_delay = 0;
    for (int i = 0; i < N; i++) issue(i, (32'h1000_0000 * (i + 1)) | W'($urandom_range(0, 65535)));
    for (int op = 0; op < 5; op++) begin
      g = -1;
      for (int i = 0; i < 20; i++) begin
        if (req_ready != '0) break;
        tick();
      end
      for (int j = N - 1; j >= 0; j--) if (req_ready[j]) g = j;
      checks++; if (g != op % N) begin errors++; $display("FAIL rr_order op %0d got %0d want %0d", op, g, op % N); end
      if (g < 0) g = 0;
      acc = req_data[g*W +: W];
      exp_q.push_back(cipher_f(acc));
      tick();
      checks++; if (grant_id !== 2'(g)) begin errors++; $display("FAIL rr_gid got %0d want %0d", grant_id, g); end
      for (int j = 0; j < N; j++) req_data[j*W +: W] = $urandom;
      tick(); tick();
      checks++; if (les_plaintext !== acc) begin errors++; $display("FAIL rr_pt_stable got %h want %h", les_plaintext, acc); end
      bad = 1'b0; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (req_ready != '0) bad = 1'b1;
        if (resp_valid != '0) begin ok = 1'b1; break; end
        tick();
      end
      checks++; if (!ok || bad) begin errors++; $display("FAIL rr_exclusive got ok=%b stray_ready=%b want 1 0", ok, bad); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++; if (resp_valid !== (4'b0001 << g) || resp_data !== e) begin
        errors++; $display("FAIL rr_resp got valid=%b data=%h want valid=%b data=%h", resp_valid, resp_data, 4'b0001 << g, e);
      end
      resp_ready = resp_valid; tick(); resp_ready = '0;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    bit ok; bit bad; logic [W-1:0] snap; logic [W-1:0] e;
    busy_len = 5; busy_delay = 0;
    tick();
    issue(1, 32'hB00B_1E55);
    exp_q.push_back(cipher_f(32'hB00B_1E55));
    tick(); req_valid = '0;
    wait_resp(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_wait got no resp_valid want resp_valid"); end
    snap = resp_data;
    resp_ready = 4'b0100; req_valid = 4'b0001;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (resp_valid !== 4'b0010 || resp_data !== snap || req_ready !== 4'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_hold got valid=%b ready=%b data=%h want valid=0010 ready=0000 stable", resp_valid, req_ready, resp_data); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (snap !== e) begin errors++; $display("FAIL bp_data got %h want %h", snap, e); end
    req_valid = '0; resp_ready = 4'b0010; tick(); resp_ready = '0;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL bp_return got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_delayed_busy();
    int c0; bit ok; bit bad; logic [W-1:0] e;
    busy_len = 8; busy_delay = 3;
    tick();
    issue(2, 32'h0DE1_A7ED);
    c0 = cyc;
    exp_q.push_back(cipher_f(32'h0DE1_A7ED));
    tick(); req_valid = '0;
    tick(); tick();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dbg_state !== ST_WAIT_HI) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL delay_wait_hi got state %0d want %0d", dbg_state, ST_WAIT_HI); end
    wait_resp(60, ok);
    checks++; if (!ok || cyc - c0 != 15) begin errors++; $display("FAIL delay_latency got ok=%b lat=%0d want 1 15", ok, cyc - c0); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (resp_data !== e || resp_valid !== 4'b0100) begin errors++; $display("FAIL delay_data got %h/%b want %h/0100", resp_data, resp_valid, e); end
    resp_ready = 4'b0100; tick(); resp_ready = '0;
    busy_delay = 0;
  endtask

  task automatic test_reset_mid_op();
    bit ok; logic [W-1:0] e;
    busy_len = 32;
    issue(0, 32'h1234_5678);
    tick(); req_valid = '0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dbg_state === ST_WAIT_LO) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach_wait_lo got %0d want %0d", dbg_state, ST_WAIT_LO); end
    tick(); tick();
    resetn = 1'b0; #1;
    checks++; if (dbg_state !== ST_IDLE || resp_valid !== 4'b0 || les_clr !== 1'b0 || les_start !== 1'b0) begin
      errors++; $display("FAIL rst_async_ctl got state=%0d valid=%b clr=%b start=%b want 0", dbg_state, resp_valid, les_clr, les_start);
    end
    checks++; if (les_plaintext !== '0 || resp_data !== '0 || grant_id !== 2'd0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL rst_async_data got pt=%h data=%h gid=%0d err=%b want 0", les_plaintext, resp_data, grant_id, resp_err);
    end
    exp_q.delete();
    tick(); tick();
    resetn = 1'b1;
    busy_len = 6;
    issue(3, 32'h3333_3333);
    issue(2, 32'h2222_2222);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_first_grant got %b want 0100", req_ready); end
    exp_q.push_back(cipher_f(32'h2222_2222));
    tick(); req_valid = '0;
    wait_resp(80, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (!ok || resp_valid !== 4'b0100 || resp_data !== e) begin
      errors++; $display("FAIL rst_after_op got valid=%b data=%h want 0100 %h", resp_valid, resp_data, e);
    end
    resp_ready = 4'b0100; tick(); resp_ready = '0;
  endtask

`ifdef LES_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c0; bit ok; logic [W-1:0] e;
    busy_len = 4; stuck = 1'b1;
    tick();
    issue(3, 32'hDEAD_BEEF);
    c0 = cyc;
    exp_q.push_back('0);
    tick(); req_valid = '0;
    wait_resp(80, ok);
    checks++; if (!ok || cyc - c0 != 18) begin errors++; $display("FAIL to_latency got ok=%b lat=%0d want 1 18", ok, cyc - c0); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++; if (resp_err !== 1'b1 || resp_data !== e) begin errors++; $display("FAIL to_abort got err=%b data=%h want 1 %h", resp_err, resp_data, e); end
    resp_ready = 4'b1000; tick(); resp_ready = '0;
    stuck = 1'b0;
    issue(0, 32'h0F0F_1234);
    exp_q.push_back(cipher_f(32'h0F0F_1234));
    tick(); req_valid = '0;
    wait_resp(80, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (!ok || resp_err !== 1'b0 || resp_data !== e) begin
      errors++; $display("FAIL to_recover got ok=%b err=%b data=%h want 1 0 %h", ok, resp_err, resp_data, e);
    end
    resp_ready = 4'b0001; tick(); resp_ready = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_delayed_busy();
    test_reset_mid_op();
`ifdef LES_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/les_arbiter.md
Name: les_arbiter

Overview:
- Shares a single les_top cipher core between N_REQ independent requesters.
- Round-robin grant; per request sequences the core clr -> start -> busy-high -> busy-low, then captures cipher_out and returns it to the granted requester.
- Sits between requester logic (LFSR sources, UART/host command paths) and the one les_top instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 32, plaintext/cipher width, matches les_top
TIMEOUT_CYCLES, 1023, watchdog limit in cycles (used only with LES_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  one-hot accept; data taken when valid & ready
req_data  in  N_REQ*DATA_W  plaintexts; requester i at bits [i*DATA_W +: DATA_W]
resp_valid  out  N_REQ  one-hot result valid to the owning requester
resp_ready  in  N_REQ  per-requester result accept
resp_data  out  DATA_W  cipher result, shared bus, qualified by resp_valid
resp_err  out  1  result is a timeout abort (0 without feature)
les_clr  out  1  to les_top clr
les_start  out  1  to les_top start
les_plaintext  out  DATA_W  to les_top plaintext_in, held stable for the whole op
les_cipher  in  DATA_W  from les_top cipher_out
les_busy  in  1  from les_top busy
grant_id  out  $clog2(N_REQ)  index of current owner; valid when not IDLE

Behaviour:
- Reset (async, resetn=0): state IDLE; req_ready=0, resp_valid=0, resp_data=0, resp_err=0, les_clr=0, les_start=0, les_plaintext=0, grant_id=0, rr pointer=N_REQ-1 so requester 0 wins first.
- States: IDLE, CLR, START, WAIT_HI, WAIT_LO, RESP. les_clr=1 only in CLR; les_start=1 only in START (Moore decode, one cycle each).
- IDLE: if any req_valid, req_ready[g]=1 combinationally for the rr winner g in that same cycle. Latch req_data[g] into les_plaintext, grant_id<=g, rr pointer<=g, -> CLR.
- Round robin: search starts at pointer+1 mod N_REQ, wraps. A requester just served has lowest priority next.
- CLR -> START unconditionally. START -> WAIT_HI.
- WAIT_HI: stay until les_busy=1, then -> WAIT_LO. Handles cores asserting busy one or more cycles after start.
- WAIT_LO: stay while les_busy=1. On les_busy=0: resp_data<=les_cipher, resp_err<=0, -> RESP.
- RESP: resp_valid[grant_id]=1, resp_data held. On resp_ready[grant_id]=1 -> IDLE.
  - resp_ready of other requesters is ignored.
  - A new grant is possible the cycle after return to IDLE, giving 1 idle cycle between ops.
- Latency, accept to resp_valid: 4 + B cycles, where B = busy-high duration plus any start->busy delay.
- Only one request is ever outstanding; all other req_ready stay 0 from grant until IDLE.
- req_valid dropping after accept has no effect. req_data changing after accept has no effect.
- Reset mid-op aborts with no response. The next op's CLR re-initialises the core.

Optional Feature:
- Macro LES_ARB_TIMEOUT_EN.
- Defined: a cycle counter clears on entering WAIT_HI and runs through WAIT_HI/WAIT_LO. On reaching TIMEOUT_CYCLES -> RESP with resp_data=0 and resp_err=1.
- Undefined: no counter, resp_err tied 0, and the block waits indefinitely for les_busy.

Decomposition:
- Package les_pkg: LES_DATA_W=32, state enum les_arb_state_t (6 states), requester-index width helper.
- Sub-module les_rr_arbiter: combinational N_REQ round-robin winner from req_valid and pointer, outputting a one-hot grant and an index. The pointer register stays in les_arbiter.

Test Plan:
- Single op: model with busy=1 for 32 cycles; req_valid[0], data 0xACE1ACE1 -> req_ready[0] same cycle, les_clr at +1, les_start at +2, resp_valid[0] with model cipher at +36, resp_err=0.
- Round robin: req_valid=4'b1111 held, each resp_ready immediate -> grant order 0,1,2,3,0; req_data of the non-owner changed mid-op -> les_plaintext unchanged.
- Backpressure: resp_ready[1] held 0 for 10 cycles -> resp_valid[1] and resp_data stable; resp_ready[2]=1 in that window ignored; no new grant.
- Delayed busy: model raises busy 3 cycles after start -> arbiter stays in WAIT_HI, then completes normally with the correct cipher.
- Reset mid-op: resetn low during WAIT_LO -> all outputs 0 asynchronously; after release, req_valid[2] is granted first if 0/1 are idle, and the op completes.
- Timeout (LES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15): model busy stuck high -> resp_valid after 15 cycles in wait, resp_err=1, resp_data=0; next request served normally.
